// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank: FSM/field codes, time digit widths,
// the packed alarm-time struct and a wrap-around digit stepper.
package alarm_pkg;

   localparam int HOUR_W = 5;
   localparam int TMIN_W = 3;
   localparam int MIN_W  = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_E_HR  = 2'd1;
   localparam logic [1:0] S_E_TM  = 2'd2;
   localparam logic [1:0] S_E_MIN = 2'd3;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_TMIN = 2'd2;
   localparam logic [1:0] FIELD_MIN  = 2'd3;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [TMIN_W-1:0] t_min;
      logic [MIN_W-1:0]  min;
   } alarm_time_t;

   function automatic logic [HOUR_W-1:0] wrap_step(input logic [HOUR_W-1:0] v,
                                                   input logic [HOUR_W-1:0] top,
                                                   input logic dec);
      if (dec) return (v == '0) ? top : v - HOUR_W'(1);
      return (v == top) ? '0 : v + HOUR_W'(1);
   endfunction

endpackage

// File: rtl/alarm_time_add.sv
// Combinational time + ADD_MIN minutes with min -> tens -> hour carries (ADD_MIN <= 9).
module alarm_time_add
   import alarm_pkg::*;
#(
   parameter int HOUR_MAX = 11,
   parameter int ADD_MIN  = 5
) (
   input  alarm_time_t t,
   output alarm_time_t sum
);

   logic [MIN_W:0]  min_raw;
   logic [TMIN_W:0] tmin_raw;
   logic [HOUR_W:0] hour_raw;
   logic            min_c;
   logic            tmin_c;

   always_comb begin
      sum      = '0;
      min_raw  = {1'b0, t.min} + (MIN_W+1)'(ADD_MIN);
      min_c    = (min_raw >= (MIN_W+1)'(10));
      sum.min  = min_c ? MIN_W'(min_raw - (MIN_W+1)'(10)) : min_raw[MIN_W-1:0];
      tmin_raw = {1'b0, t.t_min} + {{TMIN_W{1'b0}}, min_c};
      tmin_c   = (tmin_raw >= (TMIN_W+1)'(6));
      sum.t_min = tmin_c ? '0 : tmin_raw[TMIN_W-1:0];
      hour_raw = {1'b0, t.hour} + {{HOUR_W{1'b0}}, tmin_c};
      sum.hour = (hour_raw > (HOUR_W+1)'(HOUR_MAX)) ? '0 : hour_raw[HOUR_W-1:0];
   end

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm: field editor FSM, per-slot arming, minute compare and ring control.
// Optional snooze is enabled by defining ALARM_SNOOZE_EN.
//
//   state   | meaning
//   IDLE    | not editing; display follows sel, up toggles arm flag
//   E_HR    | editing hour of slot edit_idx
//   E_TM    | editing tens-of-minutes of slot edit_idx
//   E_MIN   | editing minutes of slot edit_idx
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int sys_freq   = 100000000,
   parameter int NUM_ALARMS = 4,
   parameter int HOUR_MAX   = 11,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 1,
   localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  center,
   input  logic                  up,
   input  logic                  down,
   input  logic                  left,
   input  logic                  right,
   input  logic                  edit_en,
   input  logic [IDX_W-1:0]      sel,
   input  logic [HOUR_W-1:0]     cur_hour,
   input  logic [TMIN_W-1:0]     cur_t_min,
   input  logic [MIN_W-1:0]      cur_min,
   input  logic                  min_tick,
   output logic [HOUR_W-1:0]     hour,
   output logic [TMIN_W-1:0]     t_min,
   output logic [MIN_W-1:0]      min,
   output logic [1:0]            field,
   output logic                  dp,
   output logic [NUM_ALARMS-1:0] armed,
   output logic                  ringing,
   output logic [IDX_W-1:0]      ring_id
);

   localparam int DP_DIV = (sys_freq / 4 > 0) ? sys_freq / 4 : 1;
   localparam int DP_W   = $clog2(DP_DIV + 1);
   localparam int RT_W   = $clog2(RING_MIN + 1);
   localparam logic [HOUR_W-1:0] HOUR_TOP = HOUR_W'(HOUR_MAX);

   logic [1:0]       state;
   logic [IDX_W-1:0] edit_idx;
   logic [IDX_W-1:0] disp_idx;
   logic [IDX_W-1:0] hit_id;
   logic [IDX_W-1:0] trig_id;
   logic             hit_any;
   logic             trig;
   logic             ring_btn;
   logic             ring_stop;
   logic             dp_q;
   logic [DP_W-1:0]  dp_div;
   logic [RT_W-1:0]  ring_timer;
   alarm_time_t      slots [NUM_ALARMS];
   alarm_time_t      cur_time;
   alarm_time_t      edit_time;
   alarm_time_t      stepped;
   alarm_time_t      snooze_sum;

   assign cur_time  = {cur_hour, cur_t_min, cur_min};
   assign disp_idx  = (state == S_IDLE) ? sel : edit_idx;
   assign edit_time = slots[edit_idx];
   assign {hour, t_min, min} = slots[disp_idx];
   assign field     = state;
   assign dp        = dp_q & (state != S_IDLE);
   assign ring_btn  = ringing & (center | up);

   alarm_time_add #(.HOUR_MAX(HOUR_MAX), .ADD_MIN(SNOOZE_MIN)) u_snooze_add (
      .t   (cur_time),
      .sum (snooze_sum)
   );

   always_comb begin
      stepped = edit_time;
      case (state)
         S_E_HR:  stepped.hour  = wrap_step(edit_time.hour, HOUR_TOP, !up);
         S_E_TM:  stepped.t_min = TMIN_W'(wrap_step(HOUR_W'(edit_time.t_min), HOUR_W'(5), !up));
         S_E_MIN: stepped.min   = MIN_W'(wrap_step(HOUR_W'(edit_time.min), HOUR_W'(9), !up));
         default: stepped = edit_time;
      endcase
   end

   always_comb begin
      hit_any = 1'b0;
      hit_id  = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (armed[i] && (slots[i] == cur_time)) begin
            hit_any = 1'b1;
            hit_id  = IDX_W'(i);
         end
      end
   end

   // center/up belong to the ring logic while ringing, so the editor never sees them then
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         edit_idx <= '0;
         armed    <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) slots[i] <= '0;
      end else if (state != S_IDLE && !edit_en) begin
         state <= S_IDLE;
      end else if (!ring_btn) begin
         if (state == S_IDLE) begin
            if (center) begin
               if (edit_en) begin
                  edit_idx <= sel;
                  state    <= S_E_HR;
               end
            end else if (up && !edit_en) begin
               armed[sel] <= ~armed[sel];
            end
         end else begin
            if (center) begin
               armed[edit_idx] <= 1'b1;
               state           <= S_IDLE;
            end else if (up || down) begin
               slots[edit_idx] <= stepped;
            end else if (right) begin
               state <= (state == S_E_MIN) ? S_E_HR : state + 2'd1;
            end else if (left) begin
               state <= (state == S_E_HR) ? S_E_MIN : state - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dp_q   <= 1'b0;
         dp_div <= '0;
      end else if (state == S_IDLE) begin
         dp_q   <= 1'b0;
         dp_div <= '0;
      end else if (dp_div == DP_W'(DP_DIV - 1)) begin
         dp_q   <= ~dp_q;
         dp_div <= '0;
      end else begin
         dp_div <= dp_div + DP_W'(1);
      end
   end

`ifdef ALARM_SNOOZE_EN
   logic             snooze_valid;
   logic             snooze_hit;
   logic [IDX_W-1:0] snooze_id;
   alarm_time_t      snooze_time;

   assign snooze_hit = snooze_valid && (snooze_time == cur_time);
   assign ring_stop  = ringing & (center | up);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snooze_valid <= 1'b0;
         snooze_id    <= '0;
         snooze_time  <= '0;
      end else if (min_tick && snooze_hit) begin
         snooze_valid <= 1'b0;
      end else if (ringing && !trig && center) begin
         snooze_valid <= 1'b0;
      end else if (ringing && !trig && up) begin
         snooze_valid <= 1'b1;
         snooze_id    <= ring_id;
         snooze_time  <= snooze_sum;
      end
   end
`else
   logic unused_snooze;
   assign unused_snooze = ^snooze_sum;
   assign ring_stop     = ringing & center;
`endif

   always_comb begin
      trig    = min_tick & hit_any;
      trig_id = (ringing && (ring_id < hit_id)) ? ring_id : hit_id;
`ifdef ALARM_SNOOZE_EN
      if (min_tick && snooze_hit) begin
         trig = 1'b1;
         if (!hit_any || (snooze_id < trig_id)) trig_id = snooze_id;
      end
`endif
   end

   // ring_timer is a down-counter of remaining unattended minutes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ringing    <= 1'b0;
         ring_id    <= '0;
         ring_timer <= '0;
      end else if (trig) begin
         ringing    <= 1'b1;
         ring_id    <= trig_id;
         ring_timer <= RT_W'(RING_MIN);
      end else if (ring_stop) begin
         ringing    <= 1'b0;
         ring_timer <= '0;
      end else if (ringing && min_tick) begin
         if (ring_timer <= RT_W'(1)) begin
            ringing    <= 1'b0;
            ring_timer <= '0;
         end else begin
            ring_timer <= ring_timer - RT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: a 12-hour/RING_MIN=2 instance and a 24-hour/RING_MIN=1
// instance share all stimulus; expectations are hand-computed per step.
module tb_alarm_bank;

   localparam logic [4:0] B_C = 5'b10000;
   localparam logic [4:0] B_U = 5'b01000;
   localparam logic [4:0] B_D = 5'b00100;
   localparam logic [4:0] B_R = 5'b00010;
   localparam logic [4:0] B_L = 5'b00001;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       center, up, down, left, right, edit_en, min_tick;
   logic [1:0] sel;
   logic [4:0] cur_hour;
   logic [2:0] cur_t_min;
   logic [3:0] cur_min;

   logic [4:0] hour, hour24;
   logic [2:0] t_min, t_min24;
   logic [3:0] min, min24;
   logic [1:0] field, field24;
   logic       dp, dp24;
   logic [3:0] armed, armed24;
   logic       ringing, ringing24;
   logic [1:0] ring_id, ring_id24;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alarm_bank #(.sys_freq(40), .NUM_ALARMS(4), .HOUR_MAX(11), .SNOOZE_MIN(5), .RING_MIN(2)) dut (
      .clk(clk), .rst(rst), .center(center), .up(up), .down(down), .left(left), .right(right),
      .edit_en(edit_en), .sel(sel), .cur_hour(cur_hour), .cur_t_min(cur_t_min), .cur_min(cur_min),
      .min_tick(min_tick), .hour(hour), .t_min(t_min), .min(min), .field(field), .dp(dp),
      .armed(armed), .ringing(ringing), .ring_id(ring_id)
   );

   alarm_bank #(.sys_freq(40), .NUM_ALARMS(4), .HOUR_MAX(23), .SNOOZE_MIN(5), .RING_MIN(1)) dut24 (
      .clk(clk), .rst(rst), .center(center), .up(up), .down(down), .left(left), .right(right),
      .edit_en(edit_en), .sel(sel), .cur_hour(cur_hour), .cur_t_min(cur_t_min), .cur_min(cur_min),
      .min_tick(min_tick), .hour(hour24), .t_min(t_min24), .min(min24), .field(field24), .dp(dp24),
      .armed(armed24), .ringing(ringing24), .ring_id(ring_id24)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [4:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         {center, up, down, right, left} = b;
         tick();
         {center, up, down, right, left} = '0;
      end
   endtask

   task automatic min_pulse(input int h, input int tm, input int m);
      cur_hour  = 5'(h);
      cur_t_min = 3'(tm);
      cur_min   = 4'(m);
      min_tick  = 1'b1;
      tick();
      min_tick  = 1'b0;
   endtask

   initial begin
      {center, up, down, right, left} = '0;
      edit_en = 1'b0; min_tick = 1'b0; sel = 2'd0;
      cur_hour = '0; cur_t_min = '0; cur_min = '0;
      tick_n(2);
      check("rst_field", field, 0);
      check("rst_dp", dp, 0);
      check("rst_armed", armed, 0);
      check("rst_ringing", ringing, 0);
      check("rst_ring_id", ring_id, 0);
      check("rst_time", {hour, t_min, min}, 0);
      rst = 1'b1;
      tick();

      // slot 2 -> 3:09 and armed
      edit_en = 1'b1; sel = 2'd2;
      push(B_C, 1);  check("edit_field_hr", field, 1);
      push(B_U, 3);  check("edit_hour", hour, 3);
      push(B_R, 1);  check("edit_field_tm", field, 2);
      push(B_U, 6);  check("edit_tmin_wrap", t_min, 0);
      push(B_R, 1);  check("edit_field_min", field, 3);
      push(B_D, 1);  check("edit_min_wrap", min, 9);
      push(B_C, 1);
      check("edit_field_exit", field, 0);
      check("edit_armed", armed, 4'b0100);
      check("edit_slot2", {hour, t_min, min}, {5'd3, 3'd0, 4'd9});
      check("edit_slot2_24", {hour24, t_min24, min24}, {5'd3, 3'd0, 4'd9});
      check("edit_field24", field24, 0);

      // hour wrap on both dials, then leave via edit_en without arming
      sel = 2'd0;
      push(B_C, 1);
      push(B_D, 1);
      check("hour_wrap_dn12", hour, 11);
      check("hour_wrap_dn24", hour24, 23);
      push(B_U, 1);
      check("hour_wrap_up12", hour, 0);
      edit_en = 1'b0;
      tick();
      check("edit_en_exit_field", field, 0);
      check("edit_en_exit_armed", armed, 4'b0100);

      // blink: period sys_freq/4 = 10 cycles
      edit_en = 1'b1;
      push(B_C, 1);
      tick_n(9);
      check("dp_before", dp, 0);
      tick();
      check("dp_toggle", dp, 1);
      check("dp_toggle24", dp24, 1);
      edit_en = 1'b0;
      tick();
      check("dp_idle", dp, 0);

      // slots 1 and 3 -> 7:30 armed
      edit_en = 1'b1;
      sel = 2'd1; push(B_C, 1); push(B_U, 7); push(B_R, 1); push(B_U, 3); push(B_C, 1);
      sel = 2'd3; push(B_C, 1); push(B_U, 7); push(B_R, 1); push(B_U, 3); push(B_L, 2);
      check("left_nav", field, 3);
      push(B_C, 1);
      edit_en = 1'b0;
      check("armed_1_3", armed, 4'b1110);
      check("armed_1_3_24", armed24, 4'b1110);
      min_pulse(7, 3, 0);
      check("ring_on", ringing, 1);
      check("ring_id_low", ring_id, 1);
      check("ring_id_low24", ring_id24, 1);
      push(B_C, 1);
      check("ring_dismiss", ringing, 0);
      check("armed_after_fire", armed, 4'b1110);

      // auto-timeout: RING_MIN=2 vs RING_MIN=1
      min_pulse(7, 3, 0);
      check("timeout_start", ringing, 1);
      min_pulse(7, 3, 1);
      check("timeout_mid", ringing, 1);
      check("timeout_24_done", ringing24, 0);
      min_pulse(7, 3, 2);
      check("timeout_done", ringing, 0);

      // disarmed match is silent
      sel = 2'd2;
      push(B_U, 1);
      check("disarm_toggle", armed, 4'b1010);
      min_pulse(3, 0, 9);
      check("disarmed_silent", ringing, 0);

      // slot 0 -> 11:58, snooze across hour wrap
      edit_en = 1'b1; sel = 2'd0;
      push(B_C, 1); push(B_D, 1); push(B_R, 1); push(B_D, 1); push(B_R, 1); push(B_D, 2); push(B_C, 1);
      edit_en = 1'b0;
      check("slot0_1158", {hour, t_min, min}, {5'd11, 3'd5, 4'd8});
      min_pulse(11, 5, 8);
      check("ring_1158", ringing, 1);
      check("ring_id_1158", ring_id, 0);
      push(B_U, 1);
      check("up_keeps_arm", armed, 4'b1011);
`ifdef ALARM_SNOOZE_EN
      check("snooze_clears", ringing, 0);
      min_pulse(0, 0, 3);
      check("snooze_ring", ringing, 1);
      check("snooze_ring_id", ring_id, 0);
`else
      check("up_ignored", ringing, 1);
`endif
      push(B_C, 1);
      check("final_dismiss", ringing, 0);
      min_pulse(0, 0, 3);
      check("no_stale_snooze", ringing, 0);

      // asynchronous reset mid-edit
      edit_en = 1'b1; sel = 2'd1;
      push(B_C, 1); push(B_U, 1);
      check("pre_rst_hour", hour, 8);
      #2 rst = 1'b0;
      #1;
      check("rst_edit_field", field, 0);
      check("rst_edit_hour", hour, 0);
      check("rst_edit_armed", armed, 0);
      tick();
      rst = 1'b1;
      edit_en = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         check("rst_slot", {hour, t_min, min}, 0);
      end

      // asynchronous reset while ringing
      sel = 2'd2;
      push(B_U, 1);
      min_pulse(0, 0, 0);
      check("ring_pre_rst", ringing, 1);
      check("ring_id_pre_rst", ring_id, 2);
      #2 rst = 1'b0;
      #1;
      check("rst_ring", ringing, 0);
      check("rst_ring_id", ring_id, 0);
      check("rst_ring_armed", armed, 0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_ring", ringing, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
